// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared memory port between instruction fetch and data load/store,
// drives the memory controls and routes read responses back after the fixed latency.
module mem_port_arbiter #(
  parameter int unsigned READ_LATENCY    = 2,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_enable,
  input  logic        if_req_valid,
  input  logic [31:0] if_req_addr,
  output logic        if_req_ready,
  output logic        if_rsp_valid,
  input  logic        d_req_valid,
  input  logic [31:0] d_req_addr,
  input  logic        d_req_we,
  input  logic [31:0] d_req_wdata,
  input  logic [1:0]  d_req_size,
  input  logic        d_req_sext,
  output logic        d_req_ready,
  output logic        d_rsp_valid,
  output logic [31:0] rsp_data,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_offset_addr,
  output logic [31:0] mem_data_in,
  output logic        mem_we,
  output logic        mem_en_byte1_s2,
  output logic        mem_en_upper_s2,
  output logic        mem_en_byte1_s3,
  output logic        mem_en_upper_s3,
  output logic        mem_sext_s3,
  input  logic [31:0] mem_data_out
);

  localparam int unsigned STREAK_W = 4;
  localparam int unsigned S3_W     = 3;
  localparam logic [1:0]  SIZE_WORD = 2'b10;

  logic                    d_win;
  logic                    grant;
  logic                    sext_s2;
  logic [1:0]              size_s2;
  logic [STREAK_W-1:0]     streak_q, streak_d;
  logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [READ_LATENCY-1:0] pipe_tag_q, pipe_tag_d;

  // Grant: D wins unless IF has already waited out a full streak of D grants.
  always_comb begin
    d_win        = d_req_valid &&
                   !(if_req_valid && (streak_q == STREAK_W'(MAX_DATA_STREAK)));
    d_req_ready  = clk_enable && !rst && d_win;
    if_req_ready = clk_enable && !rst && if_req_valid && !d_win;
    grant        = d_req_ready || if_req_ready;
  end

  // Address-phase mux; fetches are always unsigned word reads.
  always_comb begin
    mem_addr        = d_win ? d_req_addr : if_req_addr;
    mem_offset_addr = mem_addr + 32'd4;
    size_s2         = d_win ? d_req_size : SIZE_WORD;
    sext_s2         = d_win && d_req_sext;
    mem_en_byte1_s2 = (size_s2 != 2'b00);
    mem_en_upper_s2 = size_s2[1];
    mem_we          = d_req_ready && d_req_we;
    mem_data_in     = d_req_wdata;
  end

  always_comb begin
    streak_d = streak_q;
    if (clk_enable) begin
      if (d_req_ready && if_req_valid) begin
        if (streak_q < STREAK_W'(MAX_DATA_STREAK)) begin
          streak_d = streak_q + STREAK_W'(1);
        end
      end else begin
        streak_d = '0;
      end
    end
  end

  // In-flight tracker: one {valid, tag} slot per cycle of read latency.
  always_comb begin
    pipe_vld_d = pipe_vld_q;
    pipe_tag_d = pipe_tag_q;
    if (clk_enable) begin
      pipe_vld_d[0] = grant;
      pipe_tag_d[0] = d_req_ready;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        pipe_vld_d[i] = pipe_vld_q[i-1];
        pipe_tag_d[i] = pipe_tag_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q   <= '0;
      pipe_vld_q <= '0;
      pipe_tag_q <= '0;
    end else begin
      streak_q   <= streak_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_tag_q <= pipe_tag_d;
    end
  end

  assign if_rsp_valid = pipe_vld_q[READ_LATENCY-1] && !pipe_tag_q[READ_LATENCY-1];
  assign d_rsp_valid  = pipe_vld_q[READ_LATENCY-1] && pipe_tag_q[READ_LATENCY-1];
  assign rsp_data     = mem_data_out;

  // Data-phase controls; first stage captures only on a grant so idle cycles keep the last access.
  generate
    if (READ_LATENCY == 1) begin : g_s3_direct
      assign {mem_en_byte1_s3, mem_en_upper_s3, mem_sext_s3} =
             {mem_en_byte1_s2, mem_en_upper_s2, sext_s2};
    end else begin : g_s3_pipe
      localparam int unsigned S3_DEPTH = READ_LATENCY - 1;
      logic [S3_DEPTH-1:0][S3_W-1:0] s3_q, s3_d;

      always_comb begin
        s3_d = s3_q;
        if (clk_enable) begin
          if (grant) begin
            s3_d[0] = {mem_en_byte1_s2, mem_en_upper_s2, sext_s2};
          end
          for (int unsigned i = 1; i < S3_DEPTH; i++) begin
            s3_d[i] = s3_q[i-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          s3_q <= '0;
        end else begin
          s3_q <= s3_d;
        end
      end

      assign {mem_en_byte1_s3, mem_en_upper_s3, mem_sext_s3} = s3_q[S3_DEPTH-1];
    end
  endgenerate

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level reference model
// (expected-response queue keyed by enabled-cycle count, plus a read-only memory model).
module tb_mem_port_arbiter;

  localparam int RL  = 2;
  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        rst, clk_enable;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [31:0] if_req_addr;
  logic        d_req_valid, d_req_we, d_req_sext, d_req_ready, d_rsp_valid;
  logic [31:0] d_req_addr, d_req_wdata;
  logic [1:0]  d_req_size;
  logic [31:0] rsp_data, mem_addr, mem_offset_addr, mem_data_in, mem_data_out;
  logic        mem_we, mem_en_byte1_s2, mem_en_upper_s2;
  logic        mem_en_byte1_s3, mem_en_upper_s3, mem_sext_s3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.READ_LATENCY(RL), .MAX_DATA_STREAK(MAX)) dut (
    .clk(clk), .rst(rst), .clk_enable(clk_enable),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_we(d_req_we),
    .d_req_wdata(d_req_wdata), .d_req_size(d_req_size), .d_req_sext(d_req_sext),
    .d_req_ready(d_req_ready), .d_rsp_valid(d_rsp_valid), .rsp_data(rsp_data),
    .mem_addr(mem_addr), .mem_offset_addr(mem_offset_addr), .mem_data_in(mem_data_in),
    .mem_we(mem_we), .mem_en_byte1_s2(mem_en_byte1_s2), .mem_en_upper_s2(mem_en_upper_s2),
    .mem_en_byte1_s3(mem_en_byte1_s3), .mem_en_upper_s3(mem_en_upper_s3),
    .mem_sext_s3(mem_sext_s3), .mem_data_out(mem_data_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  // Memory model: registered address, registered read data.
  logic [31:0] mem_addr_r;
  always @(posedge clk) begin
    if (clk_enable) begin
      mem_addr_r   <= mem_addr;
      mem_data_out <= mem_word(mem_addr_r);
    end
  end

  typedef struct {
    int          due;
    bit          tag;
    bit          chk;
    logic [31:0] data;
  } rsp_t;

  rsp_t       exp_q[$];
  int         ecyc     = 0;
  int         streak_m = 0;
  bit         started  = 1'b0;
  logic [2:0] last_s3  = 3'b000;

  // Reference model: checks this cycle's outputs, then advances as the coming edge will.
  always @(negedge clk) begin
    bit          dw, exp_d, exp_if, r_if, r_d;
    logic [1:0]  sz;
    logic [31:0] a;
    rsp_t        e;
    dw     = d_req_valid && !(if_req_valid && streak_m >= MAX);
    exp_d  = !rst && clk_enable && dw;
    exp_if = !rst && clk_enable && if_req_valid && !dw;
    sz     = exp_d ? d_req_size : 2'b10;
    a      = exp_d ? d_req_addr : if_req_addr;
    r_if   = exp_q.size() > 0 && exp_q[0].due == ecyc && !exp_q[0].tag;
    r_d    = exp_q.size() > 0 && exp_q[0].due == ecyc && exp_q[0].tag;
    if (started) begin
      check("d_ready", d_req_ready, exp_d);
      check("if_ready", if_req_ready, exp_if);
      check("mem_we", mem_we, exp_d && d_req_we);
      if (exp_d || exp_if) begin
        check("mem_addr", mem_addr, a);
        check("offset_addr", mem_offset_addr, a + 32'd4);
        check("byte1_s2", mem_en_byte1_s2, sz != 2'b00);
        check("upper_s2", mem_en_upper_s2, sz[1]);
        if (exp_d && d_req_we) check("wdata", mem_data_in, d_req_wdata);
      end
      check("if_rsp_valid", if_rsp_valid, r_if);
      check("d_rsp_valid", d_rsp_valid, r_d);
      if ((r_if || r_d) && exp_q[0].chk) check("rsp_data", rsp_data, exp_q[0].data);
      check("s3_fields", {mem_en_byte1_s3, mem_en_upper_s3, mem_sext_s3}, last_s3);
    end
    if (rst) begin
      exp_q.delete();
      streak_m = 0;
      last_s3  = 3'b000;
      started  = 1'b1;
    end else if (started && clk_enable) begin
      if (exp_q.size() > 0 && exp_q[0].due == ecyc) void'(exp_q.pop_front());
      if (exp_d || exp_if) begin
        e.due  = ecyc + RL;
        e.tag  = exp_d;
        e.chk  = !(exp_d && d_req_we);
        e.data = mem_word(a);
        exp_q.push_back(e);
        last_s3 = {sz != 2'b00, sz[1], exp_d && d_req_sext};
      end
      if (exp_d && if_req_valid) streak_m = (streak_m < MAX) ? streak_m + 1 : MAX;
      else streak_m = 0;
      ecyc++;
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst = 1'b0; clk_enable = 1'b1; if_req_valid = 1'b0; d_req_valid = 1'b0;
    end
  endtask

  task automatic d_req(input logic [31:0] a, input logic we, input logic [1:0] sz,
                       input logic sx, input logic [31:0] wd);
    @(posedge clk); #1;
    if_req_valid = 1'b0; d_req_valid = 1'b1; d_req_addr = a; d_req_we = we;
    d_req_size = sz; d_req_sext = sx; d_req_wdata = wd;
  endtask

  initial begin
    int if_grants;
    rst = 1'b1; clk_enable = 1'b1;
    if_req_valid = 1'b0; if_req_addr = '0;
    d_req_valid = 1'b0; d_req_addr = '0; d_req_we = 1'b0; d_req_wdata = '0;
    d_req_size = 2'b00; d_req_sext = 1'b0;
    repeat (2) @(posedge clk);
    #1 if_req_valid = 1'b1; d_req_valid = 1'b1;
    @(negedge clk);
    check("rst_if_ready", if_req_ready, 1'b0);
    check("rst_d_ready", d_req_ready, 1'b0);
    idle(3);

    // Single fetch at 0x10
    @(posedge clk); #1 if_req_valid = 1'b1; if_req_addr = 32'h10;
    idle(4);

    // Starvation: both valid continuously
    if_grants = 0;
    @(posedge clk); #1;
    if_req_valid = 1'b1; if_req_addr = 32'h100;
    d_req_valid = 1'b1; d_req_addr = 32'h200; d_req_we = 1'b0; d_req_size = 2'b10;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (if_req_ready) if_grants++;
      @(posedge clk); #1;
    end
    check("starve_if_grants", 32'(if_grants), 32'd3);
    idle(4);

    // Store byte 0xA5 to 0x7FE
    d_req(32'h7FE, 1'b1, 2'b00, 1'b0, 32'hA5);
    @(negedge clk);
    check("store_we", mem_we, 1'b1);
    idle(4);

    // Signed half load at 0x3
    d_req(32'h3, 1'b0, 2'b01, 1'b1, 32'h0);
    @(negedge clk);
    check("half_offset", mem_offset_addr, 32'h7);
    idle(2);
    @(negedge clk);
    check("half_sext_s3", mem_sext_s3, 1'b1);
    check("half_byte1_s3", mem_en_byte1_s3, 1'b1);
    check("half_rsp", d_rsp_valid, 1'b1);
    idle(3);

    // Grant followed by three stalled cycles
    @(posedge clk); #1 if_req_valid = 1'b1; if_req_addr = 32'h44;
    @(posedge clk); #1 if_req_valid = 1'b0; clk_enable = 1'b0;
    repeat (2) @(posedge clk);
    idle(5);

    // Reset with a fetch in flight and a store presented in the reset cycle
    @(posedge clk); #1 if_req_valid = 1'b1; if_req_addr = 32'h88;
    @(posedge clk); #1 if_req_valid = 1'b0; rst = 1'b1;
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_wdata = 32'h1234;
    idle(5);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst          = ($urandom_range(0, 99) == 0);
      clk_enable   = ($urandom_range(0, 3) != 0);
      if_req_valid = ($urandom_range(0, 9) < 7);
      if_req_addr  = $urandom & 32'hFFFF_FFFC;
      d_req_valid  = ($urandom_range(0, 9) < 7);
      d_req_addr   = $urandom;
      d_req_we     = $urandom_range(0, 1) == 1;
      d_req_wdata  = $urandom;
      d_req_size   = 2'($urandom_range(0, 3));
      d_req_sext   = $urandom_range(0, 1) == 1;
    end
    idle(4);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
